vproc_bus_arbiter: RTL



---
 rtl/vproc_bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one VProc memory-mapped bus slave between NUM_REQ masters.
// Single outstanding slave access; a watchdog aborts accesses the slave never acknowledges.

module vproc_bus_arbiter_lane (
    input  logic we,
    input  logic rd,
    output logic pend
);
    assign pend = we | rd;
endmodule

module vproc_bus_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [31:0] ABORT_DATA  = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_rd,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [31:0]           req_rdata,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_wdata,
    output logic                  m_we,
    output logic                  m_rd,
    input  logic [31:0]           m_rdata,
    input  logic                  m_ack,
    output logic                  grant_valid,
    output logic [2:0]            grant_idx,
    output logic                  timeout_err
);
    localparam int WDW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [2:0]         last_grant, last_grant_n, grant_idx_n;
    logic [WDW-1:0]     wdcnt, wdcnt_n;
    logic [31:0]        m_addr_n, m_wdata_n, req_rdata_n;
    logic               m_we_n, m_rd_n, grant_valid_n, timeout_err_n;
    logic [NUM_REQ-1:0] req_ack_n;
    logic               xfer_end;

    logic [NUM_REQ-1:0] pend;
    logic [7:0]         pend8, we8;
    logic [7:0][31:0]   addr8, wdata8;

    vproc_bus_arbiter_lane u_lane [NUM_REQ-1:0] (
        .we   (req_we),
        .rd   (req_rd),
        .pend (pend)
    );

    // Widen per-requester views to 8 lanes so a 3-bit index selects them directly
    always_comb begin
        pend8  = '0;
        we8    = '0;
        addr8  = '0;
        wdata8 = '0;
        pend8[NUM_REQ-1:0]  = pend;
        we8[NUM_REQ-1:0]    = req_we;
        addr8[NUM_REQ-1:0]  = req_addr;
        wdata8[NUM_REQ-1:0] = req_wdata;
    end

    logic [2:0] win;
    logic       found;
    logic [3:0] cand;

    // Search begins one past the last grantee and wraps at NUM_REQ
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + 4'd1 + 4'(k);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            if (!found && pend8[cand[2:0]]) begin
                win   = cand[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        last_grant_n  = last_grant;
        grant_idx_n   = grant_idx;
        wdcnt_n       = wdcnt;
        m_addr_n      = m_addr;
        m_wdata_n     = m_wdata;
        m_we_n        = m_we;
        m_rd_n        = m_rd;
        req_rdata_n   = req_rdata;
        grant_valid_n = grant_valid;
        timeout_err_n = timeout_err;
        req_ack_n     = '0;
        xfer_end      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = BUSY;
                    grant_idx_n   = win;
                    last_grant_n  = win;
                    wdcnt_n       = '0;
                    m_addr_n      = addr8[win];
                    m_wdata_n     = wdata8[win];
                    // write wins when both strobes are raised
                    m_we_n        = we8[win];
                    m_rd_n        = ~we8[win];
                    grant_valid_n = 1'b1;
                end
            end
            BUSY: begin
                wdcnt_n = wdcnt + WDW'(1);
                if (m_ack) begin
                    xfer_end = 1'b1;
                    if (m_rd)
                        req_rdata_n = m_rdata;
                end else if (TIMEOUT_CYC != 0 && wdcnt == WD_LAST) begin
                    xfer_end      = 1'b1;
                    timeout_err_n = 1'b1;
                    if (m_rd)
                        req_rdata_n = ABORT_DATA;
                end
                if (xfer_end) begin
                    state_n = DONE;
                    m_we_n  = 1'b0;
                    m_rd_n  = 1'b0;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (grant_idx == 3'(i))
                            req_ack_n[i] = 1'b1;
                end
            end
            DONE: begin
                state_n       = IDLE;
                grant_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            last_grant  <= 3'(NUM_REQ - 1);
            grant_idx   <= '0;
            wdcnt       <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_we        <= 1'b0;
            m_rd        <= 1'b0;
            req_rdata   <= '0;
            req_ack     <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            grant_idx   <= grant_idx_n;
            wdcnt       <= wdcnt_n;
            m_addr      <= m_addr_n;
            m_wdata     <= m_wdata_n;
            m_we        <= m_we_n;
            m_rd        <= m_rd_n;
            req_rdata   <= req_rdata_n;
            req_ack     <= req_ack_n;
            grant_valid <= grant_valid_n;
            timeout_err <= timeout_err_n;
        end
    end
endmodule
